// File: rtl/anim_frame_streamer_pkg.sv
// Shared definitions for the animation frame streamer.
// Holds the FSM state encoding and the per-pixel timing constants.
// No logic; imported by the streamer top and its serializer.
package anim_frame_streamer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One RGB565 pixel on the wire.
  localparam int PIXEL_BITS = 16;

  // One FETCH cycle plus two SHIFT cycles (low, high) per bit.
  localparam int CYCLES_PER_PIXEL = 1 + 2 * PIXEL_BITS;

endpackage

// File: rtl/anim_frame_streamer_if.sv
// Bus bundle between the streamer, its frame memory and the display link.
// Pure wiring, no latency.
// No backpressure: the display side is a free-running SPI sink.
interface anim_frame_streamer_if;
  logic        start;
  logic [7:0]  ram_addr_x;
  logic [7:0]  ram_addr_y;
  logic [15:0] ram_data;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_cs_n;
  logic        spi_dc;
  logic        busy;
  logic        frame_done;

  // The streamer itself.
  modport master (
    input  start, ram_data,
    output ram_addr_x, ram_addr_y, spi_sclk, spi_mosi, spi_cs_n, spi_dc,
           busy, frame_done
  );

  // Host / memory / display side.
  modport slave (
    output start, ram_data,
    input  ram_addr_x, ram_addr_y, spi_sclk, spi_mosi, spi_cs_n, spi_dc,
           busy, frame_done
  );
endinterface

// File: rtl/anim_frame_streamer_spi_shift16.sv
// 16-bit SPI mode-0 serializer: one load, then 32 cycles of low/high sclk phases.
// Latency: bit 15 appears on mosi the cycle after load; last flags the 32nd cycle.
// No backpressure; a new load simply restarts the word.
module spi_shift16
  import anim_frame_streamer_pkg::*;
(
  input  logic        clk_24,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] data_in,
  output logic        sclk,
  output logic        mosi,
  output logic        last
);

  localparam int CW = $clog2(PIXEL_BITS);

  logic [PIXEL_BITS-1:0] sreg;
  logic [CW-1:0]         bit_cnt;
  logic                  phase;
  logic                  active;

  // Load a word, then alternate low/high phases, shifting after each high phase
  // so mosi only moves at the start of a low phase.
  always_ff @(posedge clk_24 or posedge rst) begin
    if (rst) begin
      sreg    <= '0;
      bit_cnt <= '0;
      phase   <= 1'b0;
      active  <= 1'b0;
    end else if (load) begin
      sreg    <= data_in;
      bit_cnt <= '0;
      phase   <= 1'b0;
      active  <= 1'b1;
    end else if (active) begin
      if (!phase) begin
        phase <= 1'b1;
      end else begin
        phase <= 1'b0;
        sreg  <= {sreg[PIXEL_BITS-2:0], 1'b0};
        if (bit_cnt == CW'(PIXEL_BITS - 1)) begin
          active  <= 1'b0;
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  assign sclk = phase;
  assign mosi = sreg[PIXEL_BITS-1];
  assign last = active & phase & (bit_cnt == CW'(PIXEL_BITS - 1));

endmodule

// File: rtl/anim_frame_streamer.sv
// Streams one WIDTHxHEIGHT RGB565 frame from the frame memory to an SPI display.
// Latency: 33 cycles per pixel, WIDTH*HEIGHT*33 cycles from first FETCH to DONE.
// No backpressure; start is ignored (not queued) outside IDLE.
module anim_frame_streamer
  import anim_frame_streamer_pkg::*;
#(
  parameter int WIDTH  = 96,
  parameter int HEIGHT = 64
) (
  input  logic                  clk_24,
  input  logic                  rst,
  anim_frame_streamer_if.master bus
);

  state_t     state;
  logic [7:0] x;
  logic [7:0] y;
  logic       busy;
  logic       cs_n;
  logic       dc;
  logic       done;
  logic       load;
  logic       sclk;
  logic       mosi;
  logic       last;

  // Serializer is loaded at the closing edge of the single FETCH cycle.
  assign load = (state == FETCH);

  spi_shift16 u_shift (
    .clk_24  (clk_24),
    .rst     (rst),
    .load    (load),
    .data_in (bus.ram_data),
    .sclk    (sclk),
    .mosi    (mosi),
    .last    (last)
  );

  // Frame FSM with the pixel counters and chip-select/dc as registered outputs.
  always_ff @(posedge clk_24 or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      busy  <= 1'b0;
      cs_n  <= 1'b1;
      dc    <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start) begin
            state <= FETCH;
            x     <= '0;
            y     <= '0;
            busy  <= 1'b1;
            cs_n  <= 1'b0;
            dc    <= 1'b1;
          end
        end
        FETCH: state <= SHIFT;
        SHIFT: begin
          if (last) begin
            if (x == 8'(WIDTH - 1)) begin
              x <= '0;
              if (y == 8'(HEIGHT - 1)) begin
                y     <= '0;
                state <= DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
                cs_n  <= 1'b1;
                dc    <= 1'b0;
              end else begin
                y     <= y + 8'd1;
                state <= FETCH;
              end
            end else begin
              x     <= x + 8'd1;
              state <= FETCH;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ram_addr_x = x;
  assign bus.ram_addr_y = y;
  assign bus.spi_sclk   = sclk;
  assign bus.spi_mosi   = mosi;
  assign bus.spi_cs_n   = cs_n;
  assign bus.spi_dc     = dc;
  assign bus.busy       = busy;
  assign bus.frame_done = done;

endmodule

// File: tb/tb_anim_frame_streamer.sv
// Directed bench for anim_frame_streamer with WIDTH=4, HEIGHT=2.
// A negedge monitor collects SPI words, addresses and frame_done pulses.
// Frame memory is modelled as a combinational pattern or constant source.
module tb_anim_frame_streamer;

  logic clk_24;
  logic rst;
  logic use_const;

  int n_assert;
  int n_fail;

  anim_frame_streamer_if bus ();

  anim_frame_streamer #(.WIDTH(4), .HEIGHT(2)) dut (
    .clk_24 (clk_24),
    .rst    (rst),
    .bus    (bus)
  );

  assign bus.ram_data = use_const ? 16'hA5C3 : {bus.ram_addr_x, bus.ram_addr_y};

  initial clk_24 = 1'b0;
  always #5 clk_24 = ~clk_24;

  // Monitor state
  logic [15:0] word_q[$];
  logic [15:0] addr_q[$];
  logic [15:0] acc;
  int          bits;
  int          done_cnt;
  int          mosi_viol;
  logic        prev_sclk;
  logic        prev_mosi;

  // Sample the DUT away from the active edge and rebuild words on sclk rises.
  initial begin
    prev_sclk = 1'b0;
    prev_mosi = 1'b0;
    forever begin
      @(negedge clk_24);
      if (bus.frame_done === 1'b1) done_cnt++;
      if (bus.busy === 1'b1) addr_q.push_back({bus.ram_addr_x, bus.ram_addr_y});
      if (bus.spi_sclk === 1'b1 && prev_sclk === 1'b0) begin
        acc = {acc[14:0], bus.spi_mosi};
        bits++;
        if (bits == 16) begin
          word_q.push_back(acc);
          bits = 0;
        end
      end
      if (bus.spi_sclk === 1'b1 && bus.spi_mosi !== prev_mosi) mosi_viol++;
      prev_sclk = bus.spi_sclk;
      prev_mosi = bus.spi_mosi;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge so it never races the monitor.
  task automatic mon_clear();
    #1;
    word_q.delete();
    addr_q.delete();
    acc       = '0;
    bits      = 0;
    done_cnt  = 0;
    mosi_viol = 0;
  endtask

  // Returns the number of negedges until frame_done is seen, or -1.
  task automatic wait_done(input int limit, output int cyc);
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk_24);
      if (bus.frame_done === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_24);
  endtask

  // Raise start before one posedge and drop it at the following negedge,
  // which lands in the FETCH cycle (cycle 0 of the frame).
  task automatic pulse_start();
    @(negedge clk_24);
    bus.start = 1'b1;
    @(negedge clk_24);
    bus.start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_cs_n"}, bus.spi_cs_n, 1'b1);
    check({tag, "_dc"},   bus.spi_dc, 1'b0);
    check({tag, "_sclk"}, bus.spi_sclk, 1'b0);
    check({tag, "_mosi"}, bus.spi_mosi, 1'b0);
    check({tag, "_done"}, bus.frame_done, 1'b0);
    check({tag, "_x"},    bus.ram_addr_x, 8'd0);
    check({tag, "_y"},    bus.ram_addr_y, 8'd0);
  endtask

  initial begin
    int cyc;
    int cyc2;
    int bad;
    logic [15:0] exp_w;
    logic [15:0] exp_a;

    n_assert  = 0;
    n_fail    = 0;
    use_const = 1'b0;
    bus.start = 1'b0;
    rst       = 1'b1;
    mon_clear();

    // Reset state
    wait_cycles(3);
    check_idle_outputs("reset");
    @(negedge clk_24);
    rst = 1'b0;
    mon_clear();

    // Frame 1: {x,y} pattern, timing, words and address sequence
    pulse_start();
    check("t1_busy_rise", bus.busy, 1'b1);
    check("t1_cs_n", bus.spi_cs_n, 1'b0);
    check("t1_dc", bus.spi_dc, 1'b1);
    check("t1_x0", bus.ram_addr_x, 8'd0);
    check("t1_y0", bus.ram_addr_y, 8'd0);
    wait_done(400, cyc);
    check("t1_done_cycle", cyc, 264);
    check("t1_done_busy", bus.busy, 1'b0);
    check("t1_done_cs_n", bus.spi_cs_n, 1'b1);
    check("t1_done_sclk", bus.spi_sclk, 1'b0);
    @(negedge clk_24);
    check("t1_done_width", bus.frame_done, 1'b0);
    check("t1_idle_x", bus.ram_addr_x, 8'd0);
    check("t1_idle_y", bus.ram_addr_y, 8'd0);
    #1;
    check("t1_word_count", word_q.size(), 8);
    for (int p = 0; p < 8 && p < word_q.size(); p++) begin
      exp_w = {8'(p % 4), 8'(p / 4)};
      check($sformatf("t1_word%0d", p), word_q[p], exp_w);
    end
    check("t1_addr_count", addr_q.size(), 264);
    bad = 0;
    for (int i = 0; i < addr_q.size(); i++) begin
      exp_a = {8'((i / 33) % 4), 8'((i / 33) / 4)};
      if (addr_q[i] !== exp_a) bad++;
    end
    check("t1_addr_seq_bad", bad, 0);
    check("t1_mosi_stable", mosi_viol, 0);
    check("t1_done_count", done_cnt, 1);

    // Frame 2: constant A5C3, MSB-first words
    use_const = 1'b1;
    mon_clear();
    pulse_start();
    wait_done(400, cyc);
    check("t2_done_cycle", cyc, 264);
    #1;
    check("t2_word_count", word_q.size(), 8);
    bad = 0;
    for (int i = 0; i < word_q.size(); i++) if (word_q[i] !== 16'hA5C3) bad++;
    check("t2_word_bad", bad, 0);
    check("t2_mosi_stable", mosi_viol, 0);

    // Frame 3: start pulse at cycle 100 is ignored
    use_const = 1'b0;
    wait_cycles(2);
    mon_clear();
    pulse_start();
    wait_cycles(99);
    pulse_start();
    wait_done(400, cyc);
    check("t3_done_cycle", cyc, 264 - 101);
    wait_cycles(300);
    #1;
    check("t3_done_count", done_cnt, 1);
    check("t3_busy_after", bus.busy, 1'b0);
    check("t3_word_count", word_q.size(), 8);

    // Frame 4: reset at cycle 150 aborts asynchronously, restart from (0,0)
    mon_clear();
    pulse_start();
    wait_cycles(150);
    #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("t4_async");
    @(negedge clk_24);
    rst = 1'b0;
    wait_cycles(300);
    #1;
    check("t4_no_done", done_cnt, 0);
    mon_clear();
    pulse_start();
    check("t4_restart_x", bus.ram_addr_x, 8'd0);
    check("t4_restart_y", bus.ram_addr_y, 8'd0);
    wait_cycles(33);
    check("t4_second_px_x", bus.ram_addr_x, 8'd1);
    wait_done(400, cyc);
    check("t4_done_cycle", cyc, 264 - 33);
    #1;
    check("t4_word_count", word_q.size(), 8);
    if (word_q.size() > 1) check("t4_word1", word_q[1], 16'h0100);

    // Frames 5/6: start held high, back-to-back with DONE and IDLE between
    wait_cycles(2);
    mon_clear();
    @(negedge clk_24);
    bus.start = 1'b1;
    @(negedge clk_24);
    wait_done(400, cyc);
    check("t5_first_done", cyc, 264);
    wait_done(400, cyc2);
    check("t5_second_done_gap", cyc2, 266);
    bus.start = 1'b0;
    wait_cycles(300);
    #1;
    check("t5_done_count", done_cnt, 2);
    check("t5_word_count", word_q.size(), 16);
    check_idle_outputs("t5_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
